// File: rtl/hilo_div_ctrl_if.sv
// rtl/hilo_div_ctrl_if.sv - pipeline request and divider handshake bundle for the HI/LO divide front end
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 16
);
    logic               op_valid;
    logic [2:0]         op_sel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               stall;
    logic               mf_valid;
    logic [WIDTH-1:0]   mf_data;
    logic               div_start;
    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_divisor;
    logic               div_ready;
    logic [2*WIDTH-1:0] div_result;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               dz_flag;
    logic               timeout_flag;

    modport master (
        output op_valid, op_sel, op_a, op_b, div_ready, div_result,
        input  stall, mf_valid, mf_data, div_start, div_dividend, div_divisor,
        input  hi, lo, busy, dz_flag, timeout_flag
    );

    modport slave (
        input  op_valid, op_sel, op_a, op_b, div_ready, div_result,
        output stall, mf_valid, mf_data, div_start, div_dividend, div_divisor,
        output hi, lo, busy, dz_flag, timeout_flag
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - EX-stage HI/LO front end that launches the iterative divider and captures its result
module hilo_div_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 64
) (
    input logic             clk,
    input logic             rst_n,
    hilo_div_ctrl_if.slave  bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             start_q;
    logic             dz_q;
    logic             timeout_q;
    logic             op_known;
    logic             accept;

    always_comb begin
        op_known     = bus.op_valid && (bus.op_sel <= 3'd4);
        accept       = op_known && (state == IDLE);
        bus.stall    = op_known && (state != IDLE);
        bus.mf_valid = accept && ((bus.op_sel == 3'd3) || (bus.op_sel == 3'd4));
        bus.mf_data  = '0;
        if (bus.mf_valid) begin
            bus.mf_data = (bus.op_sel == 3'd3) ? hi_q : lo_q;
        end
    end

    assign bus.div_start    = start_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.busy         = (state != IDLE);
    assign bus.dz_flag      = dz_q;
    assign bus.timeout_flag = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            start_q    <= 1'b0;
            dz_q       <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op_sel)
                            3'd0: begin
                                dz_q      <= (bus.op_b == '0);
                                timeout_q <= 1'b0;
                                if (bus.op_b != '0) begin
                                    dividend_q <= bus.op_a;
                                    divisor_q  <= bus.op_b;
                                    start_q    <= 1'b1;
                                    wait_cnt   <= '0;
                                    state      <= ARM;
                                end else begin
                                    hi_q <= bus.op_a;
                                    lo_q <= '1;
                                end
                            end
                            3'd1:    hi_q <= bus.op_a;
                            3'd2:    lo_q <= bus.op_a;
                            default: ;
                        endcase
                    end
                end
                // A ready left over from the previous divide is ignored here.
                ARM: state <= WAIT;
                WAIT: begin
                    if (bus.div_ready) begin
                        lo_q     <= bus.div_result[WIDTH-1:0];
                        hi_q     <= bus.div_result[2*WIDTH-1:WIDTH];
                        start_q  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_q <= 1'b1;
                        start_q   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - directed self-checking bench for hilo_div_ctrl
module tb_hilo_div_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl_if #(.WIDTH(16)) bus ();

    hilo_div_ctrl #(.WIDTH(16), .MAX_WAIT(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
        bus.op_valid = v;
        bus.op_sel   = sel;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 16'd0);
        bus.div_ready  = 1'b0;
        bus.div_result = '0;
        tick();
        tick();
        #4;
        checks++;
        if ({bus.busy, bus.div_start, bus.dz_flag, bus.timeout_flag, bus.mf_valid, bus.stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000000",
                     {bus.busy, bus.div_start, bus.dz_flag, bus.timeout_flag, bus.mf_valid, bus.stall});
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_dividend, bus.div_divisor, bus.mf_data} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data got hi=%h lo=%h dd=%h dv=%h mf=%h want all 0",
                     bus.hi, bus.lo, bus.div_dividend, bus.div_divisor, bus.mf_data);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int n = 0;
        tick();
        drive(1'b1, 3'd0, 16'd8, 16'd7);
        #4;
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got stall=%b busy=%b want 0 0", bus.stall, bus.busy);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            drive(1'b0, 3'd0, 16'd0, 16'd0);
            bus.div_ready  = (k == 17);
            bus.div_result = (k == 17) ? {16'd1, 16'd1} : 32'h0;
            #4;
            if (bus.busy === 1'b1 && bus.div_start === 1'b1) n++;
            if (k == 1) begin
                checks++;
                if (bus.div_dividend !== 16'd8 || bus.div_divisor !== 16'd7) begin
                    errors++;
                    $display("FAIL basic_operands got %0d/%0d want 8/7", bus.div_dividend, bus.div_divisor);
                end
            end
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 17", n);
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.hi !== 16'd1 || bus.lo !== 16'd1 || bus.busy !== 1'b0 || bus.div_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got hi=%0d lo=%0d busy=%b start=%b want 1 1 0 0",
                     bus.hi, bus.lo, bus.busy, bus.div_start);
        end
    endtask

    task automatic test_mf_stall();
        int n = 0;
        tick();
        drive(1'b1, 3'd0, 16'd51, 16'd5);
        #4;
        for (int k = 1; k <= 5; k++) begin
            tick();
            drive(1'b1, 3'd4, 16'd0, 16'd0);
            bus.div_ready  = (k == 5);
            bus.div_result = (k == 5) ? {16'd1, 16'd10} : 32'h0;
            #4;
            if (bus.stall === 1'b1 && bus.mf_valid === 1'b0) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mf_stall_cycles got %0d want 5", n);
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.stall !== 1'b0 || bus.mf_valid !== 1'b1 || bus.mf_data !== 16'd10) begin
            errors++;
            $display("FAIL mflo got stall=%b valid=%b data=%0d want 0 1 10", bus.stall, bus.mf_valid, bus.mf_data);
        end
        tick();
        drive(1'b1, 3'd3, 16'd0, 16'd0);
        #4;
        checks++;
        if (bus.mf_valid !== 1'b1 || bus.mf_data !== 16'd1) begin
            errors++;
            $display("FAIL mfhi got valid=%b data=%0d want 1 1", bus.mf_valid, bus.mf_data);
        end
    endtask

    task automatic test_div_zero();
        tick();
        drive(1'b1, 3'd0, 16'd100, 16'd0);
        #4;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL dz_accept got stall=%b want 0", bus.stall);
        end
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0);
        #4;
        checks++;
        if (bus.busy !== 1'b0 || bus.div_start !== 1'b0 || bus.hi !== 16'd100 ||
            bus.lo !== 16'hFFFF || bus.dz_flag !== 1'b1) begin
            errors++;
            $display("FAIL dz_result got busy=%b start=%b hi=%0d lo=%h dz=%b want 0 0 100 ffff 1",
                     bus.busy, bus.div_start, bus.hi, bus.lo, bus.dz_flag);
        end
        tick();
        drive(1'b1, 3'd0, 16'd9, 16'd3);
        #4;
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0);
        #4;
        checks++;
        if (bus.dz_flag !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL dz_clear got dz=%b busy=%b want 0 1", bus.dz_flag, bus.busy);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            bus.div_ready  = (k == 2);
            bus.div_result = (k == 2) ? {16'd0, 16'd3} : 32'h0;
            #4;
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.lo !== 16'd3 || bus.hi !== 16'd0) begin
            errors++;
            $display("FAIL div9_3 got hi=%0d lo=%0d want 0 3", bus.hi, bus.lo);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        tick();
        drive(1'b1, 3'd1, 16'h1234, 16'd0);
        tick();
        drive(1'b1, 3'd2, 16'h5678, 16'd0);
        tick();
        drive(1'b1, 3'd0, 16'd20, 16'd4);
        #4;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 0) drive(1'b1, 3'd5, 16'd0, 16'd0);
            else drive(1'b0, 3'd0, 16'd0, 16'd0);
            #4;
            if (k == 0) begin
                checks++;
                if (bus.stall !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored_op_stall got %b want 0", bus.stall);
                end
            end
            if (bus.div_start !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 41) begin
            errors++;
            $display("FAIL timeout_start_cycles got %0d want 41", n);
        end
        checks++;
        if (bus.timeout_flag !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 16'h1234 || bus.lo !== 16'h5678) begin
            errors++;
            $display("FAIL timeout_state got to=%b busy=%b hi=%h lo=%h want 1 0 1234 5678",
                     bus.timeout_flag, bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_stale_ready();
        tick();
        drive(1'b1, 3'd0, 16'd30, 16'd4);
        bus.div_ready  = 1'b1;
        bus.div_result = 32'hDEAD_BEEF;
        #4;
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0);
        #4;
        checks++;
        if (bus.timeout_flag !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_arm got to=%b busy=%b want 0 1", bus.timeout_flag, bus.busy);
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.busy !== 1'b1 || bus.hi !== 16'h1234 || bus.lo !== 16'h5678) begin
            errors++;
            $display("FAIL stale_masked got busy=%b hi=%h lo=%h want 1 1234 5678", bus.busy, bus.hi, bus.lo);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.div_ready  = (k == 10);
            bus.div_result = (k == 10) ? {16'd2, 16'd7} : 32'hDEAD_BEEF;
            #4;
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.hi !== 16'd2 || bus.lo !== 16'd7 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_result got hi=%0d lo=%0d busy=%b want 2 7 0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        drive(1'b1, 3'd0, 16'd51, 16'd5);
        #4;
        for (int k = 0; k < 3; k++) begin
            tick();
            drive(1'b0, 3'd0, 16'd0, 16'd0);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.div_ready  = 1'b1;
        bus.div_result = {16'd5, 16'd5};
        #4;
        checks++;
        if (bus.busy !== 1'b0 || bus.div_start !== 1'b0 || bus.hi !== 16'd0 || bus.lo !== 16'd0 ||
            bus.div_dividend !== 16'd0 || bus.div_divisor !== 16'd0 ||
            bus.dz_flag !== 1'b0 || bus.timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b start=%b hi=%h lo=%h dd=%h dv=%h dz=%b to=%b want all 0",
                     bus.busy, bus.div_start, bus.hi, bus.lo, bus.div_dividend, bus.div_divisor,
                     bus.dz_flag, bus.timeout_flag);
        end
        tick();
        bus.div_ready = 1'b0;
        #4;
        checks++;
        if (bus.hi !== 16'd0 || bus.lo !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL late_ready got hi=%h lo=%h busy=%b want 0 0 0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_mf_stall();
        test_div_zero();
        test_timeout();
        test_stale_ready();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- EX-stage front end for the 16-bit iterative divider. Decodes DIVU/MTHI/MTLO/MFHI/MFLO requests from the pipeline.
- Launches the divider with a start/ready handshake and stalls dependent instructions while it runs.
- Captures the packed quotient/remainder into the architectural HI/LO registers.
- Sits directly upstream of the divider (drives its start/dividend/divisor) and consumes its ready/result.

Parameters:
- WIDTH, 16, operand width; divider result is 2*WIDTH.
- MAX_WAIT, 64, maximum WAIT-state cycles before the divide is abandoned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  request present this cycle
- op_sel  in  3  0=DIVU, 1=MTHI, 2=MTLO, 3=MFHI, 4=MFLO; 5-7 ignored (no effect, no stall)
- op_a  in  WIDTH  dividend, or MT write data
- op_b  in  WIDTH  divisor
- stall  out  1  request not accepted this cycle; pipeline must hold it
- mf_valid  out  1  mf_data valid for an accepted MFHI/MFLO
- mf_data  out  WIDTH  HI or LO read data
- div_start  out  1  divider start, held high until ready seen
- div_dividend  out  WIDTH  registered dividend
- div_divisor  out  WIDTH  registered divisor
- div_ready  in  1  divider done
- div_result  in  2*WIDTH  [2W-1:W]=remainder, [W-1:0]=quotient
- hi  out  WIDTH  HI register (remainder)
- lo  out  WIDTH  LO register (quotient)
- busy  out  1  state != IDLE
- dz_flag  out  1  sticky divide-by-zero
- timeout_flag  out  1  sticky divider timeout

Behaviour:
- Reset: state=IDLE; hi, lo, div_dividend, div_divisor, wait counter = 0; div_start, dz_flag, timeout_flag, mf_valid = 0. Reset mid-divide abandons it; div_start drops at the same edge.
- States: IDLE, ARM, WAIT.
- Accept rule: a request is accepted when op_valid, op_sel ≤ 4 and state==IDLE. Otherwise stall=1 (combinational) for valid op_sel 0-4 while busy. stall=0 whenever op_valid=0.
- DIVU accept with op_b≠0 (cycle T):
  - Registers op_a/op_b into div_dividend/div_divisor; clears dz_flag and timeout_flag.
  - T+1: state=ARM, div_start=1. div_ready is ignored in ARM to mask a stale ready from the prior op.
  - T+2 onward: state=WAIT, div_start=1, counter increments each cycle.
- WAIT with div_ready=1 at cycle R: at the closing edge lo<=div_result[W-1:0], hi<=div_result[2W-1:W], state<=IDLE, div_start<=0, counter<=0. A request in cycle R+1 is accepted and sees the new HI/LO.
- WAIT, counter==MAX_WAIT-1 and div_ready=0: at the edge state<=IDLE, div_start<=0, timeout_flag<=1, HI/LO unchanged.
- DIVU accept with op_b==0: no launch, busy stays 0. At the edge hi<=op_a, lo<=all-ones, dz_flag<=1, timeout_flag<=0.
- MTHI/MTLO accept: hi or lo <= op_a at the edge.
- MFHI/MFLO accept: same cycle, combinational mf_valid=1 and mf_data=hi or lo (pre-edge value). Otherwise mf_valid=0 and mf_data=0.
- div_dividend/div_divisor are stable from ARM until return to IDLE.
- Simultaneous events:
  - div_ready and timeout in the same cycle: ready wins (result captured, no timeout_flag).
  - Reset overrides everything.
- Operands are unsigned. No width extension: results are taken verbatim from the divider.

Test Plan:
- Reset, then DIVU op_a=8, op_b=7 with a divider model returning after 17 cycles -> busy for ARM+WAIT, div_start high throughout; afterwards hi=1, lo=1, busy=0, div_start=0.
- DIVU 51/5, then MFLO presented on the next cycle -> stall=1 every busy cycle; MFLO accepted in cycle R+1 with mf_data=10. MFHI next -> mf_data=1.
- DIVU op_a=100, op_b=0 -> no div_start, busy=0; next cycle hi=100, lo=16'hFFFF, dz_flag=1. Subsequent DIVU 9/3 clears dz_flag; result lo=3, hi=0.
- MAX_WAIT=40, div_ready tied 0, DIVU 20/4 -> div_start high for exactly 41 cycles (ARM+40 WAIT); then timeout_flag=1, hi/lo keep prior values, busy=0.
- Stale ready: div_ready held 1 at launch, drops in ARM, rises 10 cycles later -> no capture in ARM; HI/LO written only on the later ready.
- rst_n=0 for one cycle during WAIT of 51/5 -> next cycle all outputs at reset values. A late div_ready pulse after reset is ignored (state IDLE).
